null_requant: RTL and testbench
===============================

Name: null_requant

Overview:
- Downstream stage of null_former in the CRPA chain.
- Takes the wide signed null-steered sum and rescales it by a programmable or automatically tracked right shift, with rounding and symmetric saturation, back to ADC width.
- Measures mean absolute output level and saturation count per window, so downstream correlators see a constant-width, level-controlled stream.

Parameters:
DIN_WIDTH, 32, width of signed null_former output sample
DOUT_WIDTH, 14, width of signed requantized output (ADC width)
SHIFT_WIDTH, 5, width of shift value; max shift = DIN_WIDTH-DOUT_WIDTH
WIN_LOG2, 10, measurement window = 2^WIN_LOG2 valid output samples

Ports:
clk  input  1  sample clock
resetn  input  1  asynchronous active-low reset
ce  input  1  clock enable; low freezes all state
din_valid  input  1  din qualifier
din  input  DIN_WIDTH  signed null_former sample
shift  input  SHIFT_WIDTH  manual shift, used when auto_en=0
auto_en  input  1  enable automatic shift tracking
target_pwr  input  DOUT_WIDTH-1  target mean |dout|
dout  output  DOUT_WIDTH  signed requantized sample
dout_valid  output  1  dout qualifier
shift_cur  output  SHIFT_WIDTH  shift currently applied
pwr  output  DOUT_WIDTH-1  mean |dout| of last window
pwr_valid  output  1  one-cycle pulse when pwr/sat_cnt update
sat_cnt  output  WIN_LOG2+1  saturated samples in last window

Behaviour:
- Reset: all outputs and internal registers 0; shift_cur=0.
- ce=0: no register updates, valids held; ce=1 normal operation.
- Pipeline, latency 3 cycles din_valid->dout_valid, one sample per cycle, valid delayed alongside data.
  - S1: r = din + (shift_cur>0 ? 2^(shift_cur-1) : 0), computed in DIN_WIDTH+1 bits (no overflow at +max).
  - S2: q = r >>> shift_cur (arithmetic, floor).
  - S3: saturate q to ±(2^(DOUT_WIDTH-1)-1) (symmetric; -2^(DOUT_WIDTH-1) never emitted). Register dout and a sat flag.
- shift_cur value used by a sample is the one latched when that sample enters S1; shift_cur may change only between windows, never mid-pipeline for a sample.
- Manual mode (auto_en=0): shift_cur <= min(shift, DIN_WIDTH-DOUT_WIDTH), registered every enabled cycle.
- Window logic, counting dout_valid samples:
  - acc += |dout| (acc width DOUT_WIDTH-1+WIN_LOG2); sat_acc += sat flag.
  - On the 2^WIN_LOG2-th sample (counter wraps to 0), next cycle: pwr <= (acc+|dout|)>>WIN_LOG2, sat_cnt <= final sat count, pwr_valid=1 for one cycle; acc and sat_acc restart with no lost sample.
- Auto mode (auto_en=1), evaluated at the same cycle as pwr_valid:
  - pwr > 2*target_pwr and shift_cur < max: shift_cur+1.
  - pwr < target_pwr/2 (floor) and shift_cur > 0: shift_cur-1.
  - Otherwise hold. Step is at most ±1 per window; at 0/max the value clamps.
- Switching auto_en 0->1 starts tracking from the present shift_cur. Switching 1->0 loads shift next cycle.
- Reset asserted mid-window or mid-pipeline: everything clears immediately; first window after reset is full length.

Test Plan:
(Test config: DIN_WIDTH=32, DOUT_WIDTH=14, WIN_LOG2=4.)
1. Reset: hold resetn=0 with toggling din -> dout, dout_valid, pwr, pwr_valid, sat_cnt, shift_cur all 0. Release -> first dout_valid exactly 3 cycles after first din_valid.
2. Rounding: shift=4, din=100 -> dout=6; din=-100 -> dout=-6; din=8 -> 1; din=-8 -> 0 (floor after +8).
3. Saturation: shift=0, din=20000 -> 8191, sat flag set; din=-20000 -> -8191 (not -8192). 16 such samples -> sat_cnt=16.
4. Window: shift=0, 16 valid samples din=1000 -> single pwr_valid pulse, pwr=1000, sat_cnt=0. din_valid gaps do not change the result.
5. Auto tracking: auto_en=1, target_pwr=250, constant din=16000, start shift_cur=0 -> shift_cur steps 1,2,3,4,5 at consecutive pwr_valid pulses, then holds at 5 (pwr=500). Change din to 1000 -> shift_cur decrements until pwr >= 125.
6. ce and reset: ce=0 for 5 cycles mid-stream -> outputs frozen, no samples lost or duplicated. Assert resetn at sample 8 of a window -> next window needs 16 fresh samples.

Source files
------------

// File: rtl/null_requant.sv
// Requantizer behind null_former: rounds, shifts and symmetrically saturates the wide sum
// to ADC width, and reports per-window mean |dout| and saturation count for shift tracking.
module null_requant #(
    parameter int DIN_WIDTH   = 32,
    parameter int DOUT_WIDTH  = 14,
    parameter int SHIFT_WIDTH = 5,
    parameter int WIN_LOG2    = 10
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ce,
    input  logic                          din_valid,
    input  logic signed [DIN_WIDTH-1:0]   din,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    input  logic                          auto_en,
    input  logic [DOUT_WIDTH-2:0]         target_pwr,
    output logic signed [DOUT_WIDTH-1:0]  dout,
    output logic                          dout_valid,
    output logic [SHIFT_WIDTH-1:0]        shift_cur,
    output logic [DOUT_WIDTH-2:0]         pwr,
    output logic                          pwr_valid,
    output logic [WIN_LOG2:0]             sat_cnt
);

    localparam int PW = DOUT_WIDTH - 1;
    localparam int AW = PW + WIN_LOG2;
    localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = SHIFT_WIDTH'(DIN_WIDTH - DOUT_WIDTH);
    localparam logic signed [DIN_WIDTH:0] SAT_POS = (DIN_WIDTH+1)'(2**(DOUT_WIDTH-1) - 1);
    localparam logic signed [DIN_WIDTH:0] SAT_NEG = -SAT_POS;

    logic [DIN_WIDTH:0]          rnd;
    logic signed [DIN_WIDTH:0]   r1;
    logic [SHIFT_WIDTH-1:0]      sh1;
    logic                        v1;
    logic signed [DIN_WIDTH:0]   q2;
    logic                        v2;
    logic signed [DOUT_WIDTH-1:0] dout_next;
    logic                        sat_next;
    logic                        sat3;

    logic [SHIFT_WIDTH-1:0]      shift_lim;
    logic [DOUT_WIDTH-1:0]       dout_neg;
    logic [PW-1:0]               abs_dout;
    logic [WIN_LOG2-1:0]         win_cnt;
    logic [AW-1:0]               acc;
    logic [AW-1:0]               acc_sum;
    logic [WIN_LOG2:0]           sat_acc;
    logic [WIN_LOG2:0]           sat_sum;

    // Half-LSB rounding constant for the shift this sample will see
    always_comb begin
        rnd = '0;
        if (shift_cur != '0)
            rnd = {{DIN_WIDTH{1'b0}}, 1'b1} << (shift_cur - SHIFT_WIDTH'(1));
    end

    always_comb begin
        dout_next = q2[DOUT_WIDTH-1:0];
        sat_next  = 1'b0;
        if (q2 > SAT_POS) begin
            dout_next = SAT_POS[DOUT_WIDTH-1:0];
            sat_next  = 1'b1;
        end else if (q2 < SAT_NEG) begin
            dout_next = SAT_NEG[DOUT_WIDTH-1:0];
            sat_next  = 1'b1;
        end
    end

    // The shift travels with its sample so a mid-stream change never splits a sample
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r1         <= '0;
            sh1        <= '0;
            v1         <= 1'b0;
            q2         <= '0;
            v2         <= 1'b0;
            dout       <= '0;
            sat3       <= 1'b0;
            dout_valid <= 1'b0;
        end else if (ce) begin
            r1         <= $signed({din[DIN_WIDTH-1], din} + rnd);
            sh1        <= shift_cur;
            v1         <= din_valid;
            q2         <= r1 >>> sh1;
            v2         <= v1;
            dout       <= dout_next;
            sat3       <= sat_next;
            dout_valid <= v2;
        end
    end

    always_comb begin
        shift_lim = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
        dout_neg  = -dout;
        abs_dout  = dout[DOUT_WIDTH-1] ? dout_neg[PW-1:0] : dout[PW-1:0];
        acc_sum   = acc + AW'(abs_dout);
        sat_sum   = sat_acc + (WIN_LOG2+1)'(sat3);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt   <= '0;
            acc       <= '0;
            sat_acc   <= '0;
            pwr       <= '0;
            sat_cnt   <= '0;
            pwr_valid <= 1'b0;
        end else if (ce) begin
            pwr_valid <= 1'b0;
            if (dout_valid) begin
                win_cnt <= win_cnt + WIN_LOG2'(1);
                if (win_cnt == '1) begin
                    pwr       <= acc_sum[AW-1:WIN_LOG2];
                    sat_cnt   <= sat_sum;
                    acc       <= '0;
                    sat_acc   <= '0;
                    pwr_valid <= 1'b1;
                end else begin
                    acc     <= acc_sum;
                    sat_acc <= sat_sum;
                end
            end
        end
    end

    // Auto mode moves at most one step per window, judged on the freshly published pwr
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_cur <= '0;
        end else if (ce) begin
            if (!auto_en) begin
                shift_cur <= shift_lim;
            end else if (pwr_valid) begin
                if (({1'b0, pwr} > {target_pwr, 1'b0}) && (shift_cur < SHIFT_MAX))
                    shift_cur <= shift_cur + SHIFT_WIDTH'(1);
                else if ((pwr < (target_pwr >> 1)) && (shift_cur != '0))
                    shift_cur <= shift_cur - SHIFT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_null_requant.sv
// Scoreboard bench for null_requant: expected samples queued at drive time, popped as dout
// is consumed; a window model queues expected pwr/sat_cnt and tracks the auto shift.
module tb_null_requant;

    localparam int DW = 32;
    localparam int OW = 14;
    localparam int SW = 5;
    localparam int WL = 4;
    localparam int SMAX = DW - OW;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  ce = 1'b1;
    logic                  din_valid = 1'b0;
    logic signed [DW-1:0]  din = '0;
    logic [SW-1:0]         shift = '0;
    logic                  auto_en = 1'b0;
    logic [OW-2:0]         target_pwr = '0;
    logic signed [OW-1:0]  dout;
    logic                  dout_valid;
    logic [SW-1:0]         shift_cur;
    logic [OW-2:0]         pwr;
    logic                  pwr_valid;
    logic [WL:0]           sat_cnt;

    null_requant #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .SHIFT_WIDTH(SW), .WIN_LOG2(WL)) dut (
        .clk(clk), .resetn(resetn), .ce(ce), .din_valid(din_valid), .din(din),
        .shift(shift), .auto_en(auto_en), .target_pwr(target_pwr), .dout(dout),
        .dout_valid(dout_valid), .shift_cur(shift_cur), .pwr(pwr), .pwr_valid(pwr_valid),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { longint val; bit sat; } samp_t;
    typedef struct { longint pwr; longint sat; } win_t;

    samp_t  sb_q[$];
    win_t   pwr_q[$];
    int     n_chk = 0;
    int     n_pass = 0;
    int     pwr_seen = 0;
    int     model_shift = 0;
    longint win_acc = 0;
    longint win_sat = 0;
    int     win_n = 0;

    task automatic chk_val(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic longint model_q(input longint d, input int sh, output bit sat);
        longint r;
        r = d;
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        sat = 1'b0;
        if (r > 8191) begin r = 8191; sat = 1'b1; end
        if (r < -8191) begin r = -8191; sat = 1'b1; end
        return r;
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input longint v);
        samp_t s;
        din = DW'(v);
        din_valid = 1'b1;
        s.val = model_q(v, model_shift, s.sat);
        sb_q.push_back(s);
        cyc(1);
        din_valid = 1'b0;
    endtask

    task automatic set_shift(input int v);
        shift = SW'(v);
        model_shift = (v > SMAX) ? SMAX : v;
        cyc(2);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(2);
        sb_q.delete();
        pwr_q.delete();
        win_acc = 0;
        win_sat = 0;
        win_n = 0;
        model_shift = 0;
        resetn = 1'b1;
        cyc(1);
    endtask

    task automatic wait_pwr();
        int start;
        start = pwr_seen;
        for (int i = 0; i < 200 && pwr_seen == start; i++) cyc(1);
        chk_val("pwr_wait", pwr_seen, start + 1);
    endtask

    // Consumption happens at the next posedge whenever ce is high, so count exactly once here
    always @(negedge clk) begin
        if (resetn && ce) begin
            if (dout_valid) begin
                if (sb_q.size() == 0) chk_val("dout_unexp", sb_q.size(), 1);
                else begin
                    samp_t s;
                    s = sb_q.pop_front();
                    chk_val("dout", longint'(dout), s.val);
                    win_acc += (s.val < 0) ? -s.val : s.val;
                    win_sat += s.sat;
                    win_n++;
                    if (win_n == (1 << WL)) begin
                        win_t w;
                        w.pwr = win_acc >>> WL;
                        w.sat = win_sat;
                        pwr_q.push_back(w);
                        if (auto_en) begin
                            if (w.pwr > 2 * longint'(target_pwr) && model_shift < SMAX) model_shift++;
                            else if (w.pwr < longint'(target_pwr) / 2 && model_shift > 0) model_shift--;
                        end
                        win_acc = 0;
                        win_sat = 0;
                        win_n = 0;
                    end
                end
            end
            if (pwr_valid) begin
                pwr_seen++;
                if (pwr_q.size() == 0) chk_val("pwr_unexp", pwr_q.size(), 1);
                else begin
                    win_t w;
                    w = pwr_q.pop_front();
                    chk_val("pwr", longint'(pwr), w.pwr);
                    chk_val("sat_cnt", longint'(sat_cnt), w.sat);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        int up_seq[6];
        int dn_seq[3];
        up_seq = '{1, 2, 3, 4, 5, 5};
        dn_seq = '{4, 3, 3};

        // 1. reset holds everything at zero despite input activity
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = DW'($urandom);
            din_valid = 1'(i);
            cyc(1);
        end
        chk_val("rst_dout", longint'(dout), 0);
        chk_val("rst_dout_valid", dout_valid, 0);
        chk_val("rst_pwr", pwr, 0);
        chk_val("rst_pwr_valid", pwr_valid, 0);
        chk_val("rst_sat_cnt", sat_cnt, 0);
        chk_val("rst_shift_cur", shift_cur, 0);
        din_valid = 1'b0;
        do_reset();
        set_shift(0);
        send(123);
        lat = 1;
        while (!dout_valid && lat < 20) begin
            cyc(1);
            lat++;
        end
        chk_val("latency", lat, 3);
        cyc(3);

        // 2. rounding and shift clamp
        do_reset();
        set_shift(31);
        chk_val("shift_clamp", shift_cur, SMAX);
        set_shift(4);
        chk_val("shift_manual", shift_cur, 4);
        send(100);
        send(-100);
        send(8);
        send(-8);
        cyc(6);

        // 3. symmetric saturation over a full window
        do_reset();
        set_shift(0);
        for (int i = 0; i < 16; i++) send((i % 2) ? -20000 : 20000);
        wait_pwr();

        // 4. window mean with valid gaps
        do_reset();
        set_shift(0);
        for (int i = 0; i < 16; i++) begin
            send(1000);
            cyc($urandom_range(0, 3));
        end
        wait_pwr();

        // 5. auto tracking up then down
        do_reset();
        set_shift(0);
        target_pwr = 13'd250;
        auto_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) send(16000);
            wait_pwr();
            cyc(3);
            chk_val("auto_up", shift_cur, up_seq[k]);
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) send(1000);
            wait_pwr();
            cyc(3);
            chk_val("auto_down", shift_cur, dn_seq[k]);
        end
        auto_en = 1'b0;
        set_shift(0);
        chk_val("auto_off_load", shift_cur, 0);

        // 6a. ce freeze mid-stream, din_valid held high with junk while frozen
        do_reset();
        set_shift(0);
        for (int i = 1; i <= 6; i++) send(100 * i);
        ce = 1'b0;
        din = DW'(-5555);
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk_val("freeze_valid", dout_valid, 1);
            if (sb_q.size() > 0) chk_val("freeze_dout", longint'(dout), sb_q[0].val);
        end
        ce = 1'b1;
        din_valid = 1'b0;
        for (int i = 7; i <= 16; i++) send(100 * i);
        wait_pwr();

        // 6b. reset mid-window restarts a full window
        do_reset();
        set_shift(0);
        for (int i = 0; i < 8; i++) send(500);
        do_reset();
        set_shift(0);
        base = pwr_seen;
        for (int i = 0; i < 15; i++) send(700);
        cyc(10);
        chk_val("no_pwr_at_15", pwr_seen, base);
        send(700);
        wait_pwr();
        cyc(4);

        chk_val("sb_drain", sb_q.size(), 0);
        chk_val("pwr_drain", pwr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
